// File: rtl/spi_regfile_arbiter.sv
// Arbitrates a single-port register RAM between buffered SPI writes, an SPI read-prefetch
// register that follows the SPI address, and one internal request/grant requester.
module spi_regfile_arbiter #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_spi_start,
  input  logic [DEPTH-1:0] i_spi_address,
  input  logic [WIDTH-1:0] i_spi_write_data,
  input  logic             i_spi_wren,
  output logic [WIDTH-1:0] o_spi_read_data,
  input  logic             i_int_req,
  input  logic             i_int_we,
  input  logic [DEPTH-1:0] i_int_address,
  input  logic [WIDTH-1:0] i_int_wdata,
  output logic             o_int_gnt,
  output logic [WIDTH-1:0] o_int_rdata,
  output logic             o_int_rvalid,
  output logic [DEPTH-1:0] o_ram_address,
  output logic [WIDTH-1:0] o_ram_wdata,
  output logic             o_ram_we,
  input  logic [WIDTH-1:0] i_ram_rdata,
  output logic             o_overflow
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_SPI, RD_INT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_wb_full;
  logic [DEPTH-1:0] r_wb_addr;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_refresh;
  logic             r_post_reset;
  logic [DEPTH-1:0] r_last_addr;
  logic [SW-1:0]    r_starve;
  logic [WIDTH-1:0] r_spi_rdata;
  logic [WIDTH-1:0] r_int_rdata;
  logic             r_overflow;

  logic             w_gnt, w_we, w_drain, w_issue_spi, w_refresh_set;
  logic [DEPTH-1:0] w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_starved;

  assign w_starved = (r_starve >= LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_we        = 1'b0;
    w_drain     = 1'b0;
    w_issue_spi = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (r_wb_full) begin
          w_we    = 1'b1;
          w_drain = 1'b1;
          w_addr  = r_wb_addr;
          w_wdata = r_wb_data;
        end else if (i_int_req && w_starved) begin
          w_gnt = 1'b1;
        end else if (r_refresh) begin
          w_issue_spi = 1'b1;
          w_addr      = i_spi_address;
          w_state_nxt = RD_SPI;
        end else if (i_int_req) begin
          w_gnt = 1'b1;
        end
        if (w_gnt) begin
          w_addr = i_int_address;
          if (i_int_we) begin
            w_we    = 1'b1;
            w_wdata = i_int_wdata;
          end else begin
            w_state_nxt = RD_INT;
          end
        end
      end
      RD_SPI:  w_state_nxt = IDLE;
      RD_INT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The issuing cycle compares against the stale last-fetched address, so it must not re-arm itself.
  assign w_refresh_set = i_spi_start | r_post_reset
                       | ((i_spi_address != r_last_addr) & ~w_issue_spi)
                       | (w_we & (w_addr == r_last_addr));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_wb_full    <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_refresh    <= 1'b0;
      r_post_reset <= 1'b1;
      r_last_addr  <= '0;
      r_starve     <= '0;
      r_spi_rdata  <= '0;
      r_int_rdata  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_post_reset <= 1'b0;
      r_refresh    <= w_refresh_set | (r_refresh & ~w_issue_spi);
      if (i_spi_wren) begin
        r_wb_full <= 1'b1;
        r_wb_addr <= i_spi_address;
        r_wb_data <= i_spi_write_data;
        if (r_wb_full && !w_drain) r_overflow <= 1'b1;
      end else if (w_drain) begin
        r_wb_full <= 1'b0;
      end
      if (w_issue_spi)        r_last_addr <= i_spi_address;
      if (r_state == RD_SPI)  r_spi_rdata <= i_ram_rdata;
      if (r_state == RD_INT)  r_int_rdata <= i_ram_rdata;
      if (!i_int_req || w_gnt)   r_starve <= '0;
      else if (r_starve < LIMIT) r_starve <= r_starve + 1'b1;
    end
  end

  // Combinational outputs are forced low during the reset cycle so a read in flight is dropped.
  assign o_int_gnt       = w_gnt & ~i_reset;
  assign o_ram_we        = w_we & ~i_reset;
  assign o_ram_address   = i_reset ? '0 : w_addr;
  assign o_ram_wdata     = i_reset ? '0 : w_wdata;
  assign o_int_rvalid    = (r_state == RD_INT) & ~i_reset;
  assign o_int_rdata     = i_reset ? '0 : ((r_state == RD_INT) ? i_ram_rdata : r_int_rdata);
  assign o_spi_read_data = r_spi_rdata;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// Directed bench for spi_regfile_arbiter with a behavioural single-port RAM behind it.
module tb_spi_regfile_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_start, spi_wren, int_req, int_we;
  logic [0:0] spi_address, int_address, ram_address;
  logic [7:0] spi_write_data, int_wdata, spi_read_data, int_rdata, ram_wdata, ram_rdata;
  logic       int_gnt, int_rvalid, ram_we, overflow;

  logic       ld_en;
  logic [0:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] mem [2];

  int checks = 0;
  int errors = 0;
  int waited;

  always #5 clk = ~clk;

  spi_regfile_arbiter dut (
    .i_clk(clk), .i_reset(reset), .i_spi_start(spi_start), .i_spi_address(spi_address),
    .i_spi_write_data(spi_write_data), .i_spi_wren(spi_wren), .o_spi_read_data(spi_read_data),
    .i_int_req(int_req), .i_int_we(int_we), .i_int_address(int_address), .i_int_wdata(int_wdata),
    .o_int_gnt(int_gnt), .o_int_rdata(int_rdata), .o_int_rvalid(int_rvalid),
    .o_ram_address(ram_address), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we),
    .i_ram_rdata(ram_rdata), .o_overflow(overflow)
  );

  always @(posedge clk) begin
    if (ld_en)       mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; spi_start = 1'b0; spi_wren = 1'b0; int_req = 1'b0; int_we = 1'b0;
    spi_address = 1'b0; int_address = 1'b0; spi_write_data = 8'h00; int_wdata = 8'h00;
    ld_en = 1'b1; ld_addr = 1'b0; ld_data = 8'hA5;
    nxt();
    ld_addr = 1'b1; ld_data = 8'h00;
    nxt();
    ld_en = 1'b0;
    nxt();
    #1;
    check("rst_spi_rdata", spi_read_data, 0);
    check("rst_int_gnt", int_gnt, 0);
    check("rst_rvalid", int_rvalid, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_overflow", overflow, 0);
    check("rst_int_rdata", int_rdata, 0);

    // Reset release: prefetch of address 0 lands within 4 cycles.
    reset = 1'b0;
    repeat (4) nxt();
    #1;
    check("boot_prefetch", spi_read_data, 8'hA5);
    check("boot_int_gnt", int_gnt, 0);
    check("boot_ram_we", ram_we, 0);
    check("boot_overflow", overflow, 0);

    // SPI write drains next cycle, then the prefetch picks it up.
    nxt();
    spi_address = 1'b1; spi_write_data = 8'h3C; spi_wren = 1'b1;
    nxt();
    spi_wren = 1'b0;
    #1;
    check("wb_drain_we", ram_we, 1);
    check("wb_drain_addr", ram_address, 1);
    check("wb_drain_data", ram_wdata, 8'h3C);
    repeat (3) nxt();
    #1;
    check("wb_prefetch", spi_read_data, 8'h3C);

    // Internal read with the SPI side quiet.
    ld_en = 1'b1; ld_addr = 1'b0; ld_data = 8'h11;
    nxt();
    ld_en = 1'b0;
    int_req = 1'b1; int_we = 1'b0; int_address = 1'b0;
    #1;
    check("int_rd_gnt", int_gnt, 1);
    check("int_rd_ram_we", ram_we, 0);
    nxt();
    int_req = 1'b0;
    #1;
    check("int_rd_gnt_drop", int_gnt, 0);
    check("int_rd_rvalid", int_rvalid, 1);
    check("int_rd_rdata", int_rdata, 8'h11);
    nxt();
    #1;
    check("int_rd_rvalid_drop", int_rvalid, 0);

    // Starvation: SPI address toggles every 2 cycles, internal read waits 4 denied cycles.
    spi_address = 1'b0;
    nxt();
    waited = 0;
    int_address = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k % 2 == 0) spi_address = ~spi_address;
      int_req = 1'b1;
      #1;
      if (int_gnt) break;
      waited++;
      nxt();
    end
    check("starve_gnt", int_gnt, 1);
    check("starve_denied", waited, 4);
    nxt();
    int_req = 1'b0;
    #1;
    check("starve_rvalid", int_rvalid, 1);
    check("starve_rdata", int_rdata, 8'h3C);
    repeat (5) nxt();
    #1;
    check("starve_prefetch", spi_read_data, 8'h11);

    // Back-to-back SPI writes while the RAM is tied up by an internal read.
    spi_address = 1'b1; spi_wren = 1'b1; spi_write_data = 8'h55;
    int_req = 1'b1; int_we = 1'b0; int_address = 1'b0;
    #1;
    check("ovf_gnt", int_gnt, 1);
    nxt();
    int_req = 1'b0; spi_write_data = 8'h66;
    #1;
    check("ovf_rvalid", int_rvalid, 1);
    check("ovf_not_yet", overflow, 0);
    nxt();
    spi_wren = 1'b0;
    #1;
    check("ovf_set", overflow, 1);
    check("ovf_drain_we", ram_we, 1);
    check("ovf_drain_addr", ram_address, 1);
    check("ovf_drain_data", ram_wdata, 8'h66);
    repeat (3) nxt();
    #1;
    check("ovf_prefetch", spi_read_data, 8'h66);
    check("ovf_sticky", overflow, 1);

    // SPI write and a pending internal write to the same address: SPI first, internal last.
    spi_address = 1'b0;
    nxt();
    int_req = 1'b1; int_we = 1'b1; int_address = 1'b0; int_wdata = 8'h99;
    #1;
    check("order_gnt_a1", int_gnt, 0);
    nxt();
    spi_wren = 1'b1; spi_write_data = 8'h77;
    #1;
    check("order_gnt_a2", int_gnt, 0);
    nxt();
    spi_wren = 1'b0;
    #1;
    check("order_spi_we", ram_we, 1);
    check("order_spi_data", ram_wdata, 8'h77);
    check("order_spi_gnt", int_gnt, 0);
    waited = 0;
    for (int k = 0; k < 8; k++) begin
      nxt();
      #1;
      waited++;
      if (int_gnt) break;
    end
    check("order_int_gnt", int_gnt, 1);
    check("order_int_wait", waited, 3);
    check("order_int_we", ram_we, 1);
    check("order_int_data", ram_wdata, 8'h99);
    nxt();
    int_req = 1'b0; int_we = 1'b0;
    #1;
    check("order_mem_final", mem[0], 8'h99);
    repeat (4) nxt();
    #1;
    check("order_prefetch", spi_read_data, 8'h99);

    // Reset during an internal read drops the result.
    int_req = 1'b1; int_address = 1'b1;
    #1;
    check("rstrd_gnt", int_gnt, 1);
    nxt();
    int_req = 1'b0; reset = 1'b1;
    #1;
    check("rstrd_rvalid", int_rvalid, 0);
    nxt();
    #1;
    check("rstrd_overflow", overflow, 0);
    check("rstrd_spi_rdata", spi_read_data, 0);
    reset = 1'b0;
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
